// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator operand loader.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD_A  = 2'd1,
    ST_LOAD_B  = 2'd2,
    ST_COMPARE = 2'd3
  } cmp_state_e;

  localparam int HASH_WORDS = 8;
  localparam int SIG_WORDS  = 5;
  localparam int CNT_W      = 4;

  localparam logic MODE_SIG  = 1'b0;
  localparam logic MODE_HASH = 1'b1;

endpackage

// File: rtl/cmp_loader_opnd_shift_reg.sv
// Wide operand register: synchronous clear, word-wide left shift, parallel output.
module opnd_shift_reg #(
  parameter int W      = 256,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [WORD_W-1:0] shift_in,
  output logic [W-1:0]      q
);

  logic [W-1:0] r_q;

  // New words enter at the LSB end, so the first (most significant) word ends up on top.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (shift_en) begin
      r_q <= {r_q[W-WORD_W-1:0], shift_in};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/cmp_loader.sv
// Streams operand words into the comparator's wide operand registers and captures equal.
// Optional abort input is enabled by defining CMP_LOADER_ABORT_EN.
module cmp_loader
  import cmp_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int HASH_W = 256,
  parameter int SIG_W  = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              csr,
  output logic [HASH_W-1:0] digest0,
  output logic [HASH_W-1:0] digest1,
  output logic [SIG_W-1:0]  rReg,
  output logic [SIG_W-1:0]  vReg,
  input  logic              equal,
  output logic              busy,
  output logic              done,
  output logic              result,
`ifdef CMP_LOADER_ABORT_EN
  input  logic              abort,
`endif
  output cmp_state_e        dbg_state,
  output logic [CNT_W-1:0]  dbg_cnt
);

  localparam logic [CNT_W-1:0] LAST_HASH = CNT_W'(HASH_W / WORD_W - 1);
  localparam logic [CNT_W-1:0] LAST_SIG  = CNT_W'(SIG_W / WORD_W - 1);

  cmp_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_csr;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_result;

  logic w_abort;
  logic w_hs;
  logic w_last;
  logic w_clr;
  logic w_is_hash;
  logic w_shift_a;
  logic w_shift_b;

`ifdef CMP_LOADER_ABORT_EN
  assign w_abort = abort && (r_state != ST_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Handshake: a word transfers on a rising edge where in_valid && in_ready; in_valid may
  // drop between words, and an abort in the same cycle discards the offered word.
  assign w_hs      = in_valid && r_in_ready && !w_abort;
  assign w_is_hash = (r_csr == MODE_HASH);
  assign w_last    = (r_cnt == (w_is_hash ? LAST_HASH : LAST_SIG));
  assign w_clr     = start && (r_state == ST_IDLE);
  assign w_shift_a = w_hs && (r_state == ST_LOAD_A);
  assign w_shift_b = w_hs && (r_state == ST_LOAD_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_csr      <= MODE_SIG;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_cnt      <= '0;
        r_in_ready <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_csr      <= mode;
              r_result   <= 1'b0;
              r_cnt      <= '0;
              r_state    <= ST_LOAD_A;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
          ST_LOAD_A: begin
            if (w_hs) begin
              if (w_last) begin
                r_cnt   <= '0;
                r_state <= ST_LOAD_B;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_LOAD_B: begin
            if (w_hs) begin
              if (w_last) begin
                r_cnt      <= '0;
                r_state    <= ST_COMPARE;
                r_in_ready <= 1'b0;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          ST_COMPARE: begin
            r_result <= equal;
            r_done   <= 1'b1;
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Unselected-mode registers never shift, so they stay at the zero written on start.
  opnd_shift_reg #(.W(HASH_W), .WORD_W(WORD_W)) u_digest0 (
    .clk(clk), .rst(rst), .clr(w_clr), .shift_en(w_shift_a && w_is_hash),
    .shift_in(in_data), .q(digest0)
  );

  opnd_shift_reg #(.W(HASH_W), .WORD_W(WORD_W)) u_digest1 (
    .clk(clk), .rst(rst), .clr(w_clr), .shift_en(w_shift_b && w_is_hash),
    .shift_in(in_data), .q(digest1)
  );

  opnd_shift_reg #(.W(SIG_W), .WORD_W(WORD_W)) u_rreg (
    .clk(clk), .rst(rst), .clr(w_clr), .shift_en(w_shift_a && !w_is_hash),
    .shift_in(in_data), .q(rReg)
  );

  opnd_shift_reg #(.W(SIG_W), .WORD_W(WORD_W)) u_vreg (
    .clk(clk), .rst(rst), .clr(w_clr), .shift_en(w_shift_b && !w_is_hash),
    .shift_in(in_data), .q(vReg)
  );

  assign in_ready  = r_in_ready;
  assign csr       = r_csr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;
  assign dbg_cnt   = r_cnt;

  a_ready_in_load: assert property (@(posedge clk) disable iff (rst)
    r_in_ready == ((r_state == ST_LOAD_A) || (r_state == ST_LOAD_B)));

  a_busy_not_idle: assert property (@(posedge clk) disable iff (rst)
    r_busy == (r_state != ST_IDLE));

  a_done_in_idle: assert property (@(posedge clk) disable iff (rst)
    r_done |-> (r_state == ST_IDLE));

  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    r_cnt <= (w_is_hash ? LAST_HASH : LAST_SIG));

endmodule

// File: tb/tb_cmp_loader.sv
// Bench for cmp_loader: directed table, random transactions against a word-list model,
// and hand-written reset / abort sequences.
module tb_cmp_loader;
  import cmp_pkg::*;

  localparam int WORD_W = 32;
  localparam int HASH_W = 256;
  localparam int SIG_W  = 160;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              csr;
  logic [HASH_W-1:0] digest0;
  logic [HASH_W-1:0] digest1;
  logic [SIG_W-1:0]  rReg;
  logic [SIG_W-1:0]  vReg;
  logic              equal;
  logic              busy;
  logic              done;
  logic              result;
  cmp_state_e        dbg_state;
  logic [CNT_W-1:0]  dbg_cnt;
`ifdef CMP_LOADER_ABORT_EN
  logic              abort;
`endif

  cmp_loader #(.WORD_W(WORD_W), .HASH_W(HASH_W), .SIG_W(SIG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .csr(csr), .digest0(digest0), .digest1(digest1), .rReg(rReg), .vReg(vReg),
    .equal(equal), .busy(busy), .done(done), .result(result),
`ifdef CMP_LOADER_ABORT_EN
    .abort(abort),
`endif
    .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // External comparator
  assign equal = csr ? (digest0 == digest1) : (rReg == vReg);

  // ---------------- clock / reset ----------------
  int unsigned cyc;
  initial begin
    clk = 1'b0;
    cyc = 0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_bad;
  logic [0:0] exp_q[$];

  task automatic chk(input string nm, input logic [HASH_W-1:0] act, input logic [HASH_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic             mode;
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic             gaps;
    logic             noise;
    logic             exp_result;
    int               exp_len;
  } vec_t;

  // Operand value is simply the first n words concatenated, first word most significant.
  function automatic logic [HASH_W-1:0] pack_words(input logic [7:0][31:0] w, input int n);
    logic [HASH_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) acc = {acc[HASH_W-WORD_W-1:0], w[i]};
    return acc;
  endfunction

  function automatic int words_of(input logic m);
    return (m == MODE_HASH) ? HASH_WORDS : SIG_WORDS;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, HASH_W'(busy), '0);
    chk({tag, "_in_ready"}, HASH_W'(in_ready), '0);
    chk({tag, "_done"}, HASH_W'(done), '0);
    chk({tag, "_result"}, HASH_W'(result), '0);
    chk({tag, "_csr"}, HASH_W'(csr), '0);
    chk({tag, "_digest0"}, digest0, '0);
    chk({tag, "_digest1"}, digest1, '0);
    chk({tag, "_rreg"}, HASH_W'(rReg), '0);
    chk({tag, "_vreg"}, HASH_W'(vReg), '0);
    chk({tag, "_cnt"}, HASH_W'(dbg_cnt), '0);
    chk({tag, "_state"}, HASH_W'(dbg_state), HASH_W'(ST_IDLE));
  endtask

  // ---------------- driver: one complete transaction, entered and left at a negedge ----------------
  task automatic run_txn(input vec_t v);
    int n;
    int idx;
    int budget;
    int t_start;
    int t_last;
    int t_done;
    bit got;
    logic [HASH_W-1:0] ea;
    logic [HASH_W-1:0] eb;
    logic [0:0] er;
    n  = words_of(v.mode);
    ea = pack_words(v.a, n);
    eb = pack_words(v.b, n);
    exp_q.push_back(v.exp_result);
    t_last = 0;
    t_done = 0;

    if (v.noise) begin
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data  = 32'hBAD0_0000 | 32'(i);
        chk("noise_idle_ready", HASH_W'(in_ready), '0);
        @(negedge clk);
      end
    end

    start    = 1'b1;
    mode     = v.mode;
    in_valid = v.noise;
    in_data  = 32'hBAD0_BAD0;
    t_start  = int'(cyc) + 1;
    @(negedge clk);
    start = 1'b0;

    idx = 0;
    budget = 0;
    while (idx < 2 * n && budget < 400) begin
      chk("load_cnt", HASH_W'(dbg_cnt), HASH_W'(idx % n));
      chk("load_ready", HASH_W'(in_ready), HASH_W'(1));
      chk("load_busy", HASH_W'(busy), HASH_W'(1));
      in_valid = v.gaps ? (budget % 2 == 1) : 1'b1;
      in_data  = (idx < n) ? v.a[idx] : v.b[idx - n];
      start    = v.noise && (idx == n + 1);
      if (in_valid && in_ready) begin
        if (idx == 2 * n - 1) t_last = int'(cyc) + 1;
        idx++;
      end
      budget++;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (idx < 2 * n) chk("load_timeout", HASH_W'(idx), HASH_W'(2 * n));

    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        got = 1'b1;
        t_done = int'(cyc) + 1;
        break;
      end
      in_valid = v.noise;
      @(negedge clk);
    end
    in_valid = 1'b0;
    er = exp_q.pop_front();
    chk("done_seen", HASH_W'(got), HASH_W'(1));
    if (got) begin
      chk("done_after_last", HASH_W'(t_done - t_last), HASH_W'(2));
      if (v.exp_len > 0) chk("txn_len", HASH_W'(t_done - t_start), HASH_W'(v.exp_len));
      chk("result", HASH_W'(result), HASH_W'(er));
      chk("csr", HASH_W'(csr), HASH_W'(v.mode));
      chk("done_busy", HASH_W'(busy), '0);
      if (v.mode == MODE_HASH) begin
        chk("digest0", digest0, ea);
        chk("digest1", digest1, eb);
        chk("rreg_zero", HASH_W'(rReg), '0);
        chk("vreg_zero", HASH_W'(vReg), '0);
      end else begin
        chk("rreg", HASH_W'(rReg), ea);
        chk("vreg", HASH_W'(vReg), eb);
        chk("digest0_zero", digest0, '0);
        chk("digest1_zero", digest1, '0);
      end
      @(negedge clk);
      chk("done_pulse", HASH_W'(done), '0);
      chk("result_hold", HASH_W'(result), HASH_W'(er));
    end
  endtask

  function automatic vec_t mk_random();
    vec_t v;
    int n;
    v.mode = 1'($urandom_range(0, 1));
    n = words_of(v.mode);
    v.a = '0;
    for (int i = 0; i < n; i++) v.a[i] = $urandom;
    v.b = v.a;
    if ($urandom_range(0, 1) == 1) v.b[$urandom_range(0, n - 1)] ^= (32'd1 << $urandom_range(0, 31));
    v.gaps = 1'($urandom_range(0, 1));
    v.noise = 1'($urandom_range(0, 3) == 0);
    v.exp_result = (pack_words(v.a, n) == pack_words(v.b, n));
    v.exp_len = v.gaps ? 0 : 2 * n + 2;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[6];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
`ifdef CMP_LOADER_ABORT_EN
    abort = 1'b0;
`endif

    foreach (vecs[k]) begin
      vecs[k].a = '0;
      vecs[k].b = '0;
      vecs[k].gaps = 1'b0;
      vecs[k].noise = 1'b0;
    end
    // digest match 1..8
    vecs[0].mode = 1'b1;
    for (int i = 0; i < 8; i++) vecs[0].a[i] = 32'(i + 1);
    vecs[0].b = vecs[0].a;
    vecs[0].exp_result = 1'b1;
    vecs[0].exp_len = 18;
    // signature mismatch in last B word
    vecs[1].mode = 1'b0;
    for (int i = 0; i < 5; i++) vecs[1].a[i] = 32'hDEADBEEF;
    vecs[1].b = vecs[1].a;
    vecs[1].b[4] = 32'hDEADBEEE;
    vecs[1].exp_result = 1'b0;
    vecs[1].exp_len = 12;
    // digest back-pressure
    vecs[2].mode = 1'b1;
    for (int i = 0; i < 8; i++) vecs[2].a[i] = 32'h1111_1111 * 32'(i + 1);
    vecs[2].b = vecs[2].a;
    vecs[2].gaps = 1'b1;
    vecs[2].exp_result = 1'b1;
    vecs[2].exp_len = 0;
    // signature back-pressure
    vecs[3].mode = 1'b0;
    for (int i = 0; i < 5; i++) vecs[3].a[i] = 32'hC0DE_0000 + 32'(i);
    vecs[3].b = vecs[3].a;
    vecs[3].gaps = 1'b1;
    vecs[3].exp_result = 1'b1;
    vecs[3].exp_len = 0;
    // protocol noise, mismatch in first word
    vecs[4].mode = 1'b1;
    for (int i = 0; i < 8; i++) vecs[4].a[i] = 32'hA5A5_0000 + 32'(i);
    vecs[4].b = vecs[4].a;
    vecs[4].b[0] = 32'h5A5A_0000;
    vecs[4].noise = 1'b1;
    vecs[4].exp_result = 1'b0;
    vecs[4].exp_len = 18;
    // all-zero signature operands compare equal
    vecs[5].mode = 1'b0;
    vecs[5].exp_result = 1'b1;
    vecs[5].exp_len = 12;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_txn(vecs[k]);
    for (int k = 0; k < 10; k++) run_txn(mk_random());

    // Reset after three A words of a digest transaction
    run_txn(vecs[0]);
    start = 1'b1;
    mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 32'h7700_0000 + 32'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("pre_reset_partial", digest0, HASH_W'(96'h77000000_77000001_77000002));
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_done", HASH_W'(done), '0);
      @(negedge clk);
    end
    run_txn(vecs[1]);

`ifdef CMP_LOADER_ABORT_EN
    // Abort in IDLE coincident with start is ignored; abort with 4th B word drops it
    start = 1'b1;
    mode = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_idle_ignored", HASH_W'(busy), HASH_W'(1));
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data = 32'h0AB0_0000 + 32'(i);
      abort = (i == 8);
      @(negedge clk);
    end
    in_valid = 1'b0;
    abort = 1'b0;
    chk("abort_busy", HASH_W'(busy), '0);
    chk("abort_ready", HASH_W'(in_ready), '0);
    chk("abort_state", HASH_W'(dbg_state), HASH_W'(ST_IDLE));
    chk("abort_rreg", HASH_W'(rReg),
        HASH_W'(160'h0AB00000_0AB00001_0AB00002_0AB00003_0AB00004));
    chk("abort_vreg", HASH_W'(vReg), HASH_W'(96'h0AB00005_0AB00006_0AB00007));
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", HASH_W'(done), '0);
      chk("abort_result", HASH_W'(result), '0);
      @(negedge clk);
    end
    run_txn(vecs[0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp_loader.md
# cmp_loader

Operand loader and result capture for the equality comparator. Accepts operands as a stream of 32-bit words over a valid/ready handshake and assembles them into the two wide operand registers that drive the comparator:

- digest mode: two 256-bit digests;
- signature mode: two 160-bit values (r and v).

After loading it samples the comparator's `equal` output and reports a registered pass/fail result with a one-cycle `done` pulse.

## Interface
- `WORD_W`, 32, input word width
- `HASH_W`, 256, digest operand width (multiple of `WORD_W`)
- `SIG_W`, 160, signature operand width (multiple of `WORD_W`)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a load/compare transaction
- `mode`  in  1  sampled on accepted `start`: 0 = signature (r/v), 1 = digest
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader accepts a word this cycle
- `in_data`  in  `WORD_W`  operand word, MSW first
- `csr`  out  1  latched mode, drives comparator select
- `digest0`, `digest1`  out  `HASH_W`  digest operands A, B
- `rReg`, `vReg`  out  `SIG_W`  signature operands A, B
- `equal`  in  1  comparator result, combinational from the operand outputs
- `busy`  out  1  transaction in progress
- `done`  out  1  one-cycle pulse, result valid
- `result`  out  1  latched `equal`, held until next accepted `start`

## Operation
Words per operand:
- N = `HASH_W`/`WORD_W` = 8 when `csr`=1
- N = `SIG_W`/`WORD_W` = 5 when `csr`=0

FSM states and transitions:
- **IDLE**: `in_ready`=0. An accepted `start` (only in IDLE):
  - latches `mode` into `csr`;
  - clears all four operand registers and `result`;
  - clears word counter;
  - goes to LOAD_A.
- **LOAD_A**: `in_ready`=1. Each handshake (`in_valid` & `in_ready`):
  - shifts the word into operand A (`digest0` or `rReg` per `csr`) as `{A[W-WORD_W-1:0], in_data}`;
  - increments the counter.
  - On the Nth word: counter resets, go to LOAD_B.
- **LOAD_B**: same as LOAD_A, into operand B (`digest1` or `vReg`). After the Nth word, go to COMPARE.
- **COMPARE**: `in_ready`=0. Sample `result` <= `equal`, assert `done` (registered), go to IDLE.

Further rules:
- `busy` = 1 in every state except IDLE.
- The operand registers of the unselected mode stay zero.
- `start` while busy is ignored.
- `in_valid` in IDLE or COMPARE is ignored; no word is consumed.
- `in_valid` may idle (stay low) between words; the counter holds.
- Operand outputs and `csr` hold their values after `done` until the next accepted `start`.

## Timing
- Reset values: state IDLE, `in_ready`=0, `busy`=0, `done`=0, `result`=0, `csr`=0, all operand registers 0, counter 0.
- `start` accepted in cycle t; first word can be accepted in cycle t+1.
- Minimum transaction length, `start` to `done`:
  - 2N+2 cycles;
  - 18 cycles in digest mode, 12 in signature mode.
- Last B word accepted in cycle k. Then:
  - cycle k+1: state COMPARE, `equal` sampled;
  - cycle k+2: `done`=1 and `result` valid; state IDLE.
- `start` asserted in the same cycle as `done` is accepted.
- `start` and `in_valid` in the same IDLE cycle: `start` is accepted, the word is not.
- `rst` mid-transaction: all state returns to reset values on the next edge; no `done` is issued.

## Configuration
- `CMP_LOADER_ABORT_EN` defined:
  - adds input `abort` (1 bit);
  - `abort` in any non-IDLE state returns the FSM to IDLE next cycle;
  - no `done`, `result` unchanged, operands keep their partial contents;
  - `abort` beats a simultaneous handshake (that word is dropped);
  - `abort` in IDLE has no effect.
- Not defined: no `abort` port; only `rst` terminates a transaction.

## Structure
- Shared package `cmp_pkg` holds:
  - FSM state typedef (IDLE, LOAD_A, LOAD_B, COMPARE);
  - localparams `HASH_WORDS`=8, `SIG_WORDS`=5;
  - mode constants `MODE_SIG`=0, `MODE_HASH`=1.
- Natural sub-module: `opnd_shift_reg` (parameterised width, synchronous clear, shift-enable, parallel output). Four instances, one per operand register.
- The comparator stays external; `equal` comes in as an input.

## Test plan
- Digest match: `mode`=1, A words 0x00000001..0x00000008, B identical.
  - `digest0` = `digest1` = 0x00000001_00000002_…_00000008.
  - `done` 2 cycles after the 16th word, `result`=1.
- Signature mismatch: `mode`=0, A = 5×0xDEADBEEF, B last word 0xDEADBEEE.
  - `done` after 10 words, `result`=0, `digest0`/`digest1` remain 0.
- Back-pressure: `in_valid` toggled every other cycle.
  - Exactly 2N words consumed, counter holds while idle.
  - `done` only after the 2N-th handshake.
- Protocol noise: `start` pulsed during LOAD_B, and `in_valid` high in IDLE.
  - Both ignored; `in_ready` stays 0 in IDLE.
- Reset mid-transaction: `rst` after 3 A words.
  - All outputs return to reset values on the next edge.
  - A new transaction then completes normally.
- `abort` (macro on): `abort` coincident with the 4th B word.
  - FSM returns to IDLE, no `done`, `result` unchanged, 4th word not shifted in.
